hamming_rx_frame_controller: RTL and testbench
==============================================

Name: hamming_rx_frame_controller

Overview:
- Single-clock sequencer for the 15/11 Hamming receive path.
- Counts accepted serial code bits into the 15-bit capture shift register and detects frame boundaries.
- Loads the decoded 11-bit word into the output shift register, then meters its serial drain with a ready/valid handshake.
- Reports overruns and keeps a saturating count of frames that had a non-zero syndrome. Replaces the dual-clock arrangement with one clock domain.

Parameters:
CODE_W, 15, code word length in bits (capture frame size)
DATA_W, 11, data word length in bits (output drain length)
CNT_W, 4, width of capture and drain bit counters; must satisfy 2^CNT_W >= CODE_W
ERRCNT_W, 8, width of corrected-error frame counter

Ports:
CLK  in  1  sole clock; all state updates on rising edge
REST  in  1  reset, asynchronous assert, active-low; sync deassert provided externally
DEVICE_EN  in  1  receive enable; low discards any partial frame
BIT_VALID  in  1  a new serial code bit is present this cycle
SYNDROME  in  4  syndrome from the combinational Hamming decoder
OUT_READY  in  1  downstream accepts one serial output bit this cycle
CLR_STATUS  in  1  synchronous clear of OVERRUN and ERR_COUNT
IN_SHIFT_EN  out  1  shift enable to the 15-bit capture register
WRITE_EN  out  1  parallel load to the 11-bit output register
SHIFT_EN  out  1  shift enable to the 11-bit output register
OUT_VALID  out  1  output register holds an undrained bit
FRAME_DONE  out  1  one-cycle pulse: the 15th bit of a frame was accepted last cycle
OVERRUN  out  1  sticky: a completed frame was dropped
ERR_COUNT  out  ERRCNT_W  frames loaded with SYNDROME != 0, saturating
BUSY  out  1  drain FSM not in IDLE

Behaviour:
- Reset (REST=0, async): capture counter 0; FSM IDLE; FRAME_DONE, OVERRUN, OUT_VALID, WRITE_EN, SHIFT_EN, BUSY = 0; ERR_COUNT = 0.
- Capture side:
  - IN_SHIFT_EN = BIT_VALID & DEVICE_EN (combinational, same cycle).
  - Each accepted bit increments cap_cnt. On the accepted bit with cap_cnt == CODE_W-1, cap_cnt wraps to 0 and FRAME_DONE is registered high for the next cycle only.
  - DEVICE_EN=0: cap_cnt is cleared to 0 synchronously (partial frame discarded); a FRAME_DONE already registered still occurs; drain continues unaffected.
- Drain FSM (states IDLE, SHIFT):
  - IDLE, FRAME_DONE=1: WRITE_EN=1 (Mealy, same cycle). SYNDROME is sampled that cycle; drn_cnt = 0; next state SHIFT. A BIT_VALID in that same cycle shifts the capture register at the same edge, and the load sees the pre-shift contents.
  - IDLE, FRAME_DONE=0: WRITE_EN=0; stay in IDLE.
  - SHIFT: OUT_VALID=1; SHIFT_EN = OUT_READY. Each shift increments drn_cnt. The shift with drn_cnt == DATA_W-1 returns the FSM to IDLE next cycle. OUT_READY low stalls with no state change.
  - BUSY=1 exactly while in SHIFT. WRITE_EN and SHIFT_EN are never high in the same cycle.
- Overrun:
  - FRAME_DONE while in SHIFT, including the final-shift cycle, sets OVERRUN. That frame is dropped: no WRITE_EN, and ERR_COUNT is untouched.
  - At full input rate with OUT_READY=1, no overrun occurs: load at T+1, 11 shifts, IDLE by T+13, next FRAME_DONE no earlier than T+16.
- ERR_COUNT: in the WRITE_EN cycle, if SYNDROME != 0, increment, saturating at 2^ERRCNT_W-1.
- CLR_STATUS: clears OVERRUN and ERR_COUNT at the next edge. If it coincides with a set or increment event, the clear wins.
- Reset mid-frame or mid-drain: all state returns to reset values immediately; the in-flight frame is lost and no spurious WRITE_EN or SHIFT_EN is issued.

Test Plan:
- Reset, DEVICE_EN=1, 15 consecutive BIT_VALID cycles (T0..T14), OUT_READY=1 -> FRAME_DONE and WRITE_EN high at T15 only; SHIFT_EN high T16..T26 (11 cycles); BUSY low at T27.
- Same frame with OUT_READY toggled 1/0 -> exactly 11 SHIFT_EN pulses, each coinciding with OUT_READY=1; OUT_VALID held high until the 11th.
- Hold OUT_READY=0 after a load, then complete a second frame -> OVERRUN=1, no second WRITE_EN; CLR_STATUS pulse -> OVERRUN=0.
- SYNDROME=4'b0101 on 3 loads and 0 on 2 -> ERR_COUNT=3. With ERRCNT_W=2 and 5 errored frames -> ERR_COUNT saturates at 3.
- 7 bits accepted, DEVICE_EN low for one cycle, then 15 bits -> a single FRAME_DONE, after the 15th post-enable bit.
- REST asserted during SHIFT with drn_cnt=5 -> outputs 0 asynchronously; after release, next full frame drains 11 bits normally.

Source files
------------

// File: rtl/hamming_rx_frame_controller.sv
`default_nettype none
// ============================================================================
// Module   : hamming_rx_frame_controller
// Brief    : Single-clock capture/drain sequencer for the 15/11 Hamming RX path
// Revision : 1.0
// ============================================================================
module hamming_rx_frame_controller #(
    parameter int CODE_W   = 15,
    parameter int DATA_W   = 11,
    parameter int CNT_W    = 4,
    parameter int ERRCNT_W = 8
) (
    input  logic                CLK,
    input  logic                REST,
    input  logic                DEVICE_EN,
    input  logic                BIT_VALID,
    input  logic [3:0]          SYNDROME,
    input  logic                OUT_READY,
    input  logic                CLR_STATUS,
    output logic                IN_SHIFT_EN,
    output logic                WRITE_EN,
    output logic                SHIFT_EN,
    output logic                OUT_VALID,
    output logic                FRAME_DONE,
    output logic                OVERRUN,
    output logic [ERRCNT_W-1:0] ERR_COUNT,
    output logic                BUSY
);

    localparam logic [CNT_W-1:0]    CAP_LAST = CNT_W'(CODE_W - 1);
    localparam logic [CNT_W-1:0]    DRN_LAST = CNT_W'(DATA_W - 1);
    localparam logic [ERRCNT_W-1:0] ERR_MAX  = {ERRCNT_W{1'b1}};

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [CNT_W-1:0]    cap_cnt_q, cap_cnt_d;
    logic [CNT_W-1:0]    drn_cnt_q, drn_cnt_d;
    logic                frame_done_q, frame_done_d;
    logic                overrun_q, overrun_d;
    logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                w_accept;

    assign w_accept    = BIT_VALID & DEVICE_EN;
    assign IN_SHIFT_EN = w_accept;
    assign FRAME_DONE  = frame_done_q;
    assign OVERRUN     = overrun_q;
    assign ERR_COUNT   = err_cnt_q;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK or negedge REST) begin
        if (!REST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (frame_done_q) begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (OUT_READY && (drn_cnt_q == DRN_LAST)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        WRITE_EN  = 1'b0;
        SHIFT_EN  = 1'b0;
        OUT_VALID = 1'b0;
        BUSY      = 1'b0;
        case (state_q)
            S_IDLE: begin
                WRITE_EN = frame_done_q;
            end
            S_SHIFT: begin
                OUT_VALID = 1'b1;
                BUSY      = 1'b1;
                SHIFT_EN  = OUT_READY;
            end
            default: ;
        endcase
    end

    // ---------------- Counters and status ----------------
    always_comb begin
        cap_cnt_d    = cap_cnt_q;
        frame_done_d = 1'b0;
        if (!DEVICE_EN) begin
            cap_cnt_d = '0;
        end else if (BIT_VALID) begin
            if (cap_cnt_q == CAP_LAST) begin
                cap_cnt_d    = '0;
                frame_done_d = 1'b1;
            end else begin
                cap_cnt_d = cap_cnt_q + 1'b1;
            end
        end

        drn_cnt_d = drn_cnt_q;
        if (WRITE_EN) begin
            drn_cnt_d = '0;
        end else if (SHIFT_EN) begin
            drn_cnt_d = drn_cnt_q + 1'b1;
        end

        // A frame completing while the drain is busy is dropped and flagged.
        overrun_d = overrun_q | (frame_done_q & (state_q == S_SHIFT));
        err_cnt_d = err_cnt_q;
        if (WRITE_EN && (SYNDROME != 4'd0) && (err_cnt_q != ERR_MAX)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
        if (CLR_STATUS) begin
            overrun_d = 1'b0;
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge REST) begin
        if (!REST) begin
            cap_cnt_q    <= '0;
            drn_cnt_q    <= '0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            cap_cnt_q    <= cap_cnt_d;
            drn_cnt_q    <= drn_cnt_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hamming_rx_frame_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_hamming_rx_frame_controller
// Brief    : Randomized bench against a frame/drain occupancy reference model
// Revision : 1.0
// ============================================================================
module tb_hamming_rx_frame_controller;

    logic       CLK = 1'b0;
    logic       REST = 1'b0;
    logic       DEVICE_EN = 1'b0;
    logic       BIT_VALID = 1'b0;
    logic [3:0] SYNDROME = 4'd0;
    logic       OUT_READY = 1'b0;
    logic       CLR_STATUS = 1'b0;

    logic       IN_SHIFT_EN, WRITE_EN, SHIFT_EN, OUT_VALID, FRAME_DONE, OVERRUN, BUSY;
    logic [7:0] ERR_COUNT;
    logic       IN_SHIFT_EN2, WRITE_EN2, SHIFT_EN2, OUT_VALID2, FRAME_DONE2, OVERRUN2, BUSY2;
    logic [1:0] ERR_COUNT2;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: bits into current frame, pending completed frame,
    // output bits still to drain, sticky overrun, error frame counts.
    int m_bits = 0;
    bit m_done = 1'b0;
    int m_left = 0;
    bit m_ovr  = 1'b0;
    int m_err  = 0;
    int m_err2 = 0;

    always #5 CLK = ~CLK;

    hamming_rx_frame_controller dut (
        .CLK(CLK), .REST(REST), .DEVICE_EN(DEVICE_EN), .BIT_VALID(BIT_VALID),
        .SYNDROME(SYNDROME), .OUT_READY(OUT_READY), .CLR_STATUS(CLR_STATUS),
        .IN_SHIFT_EN(IN_SHIFT_EN), .WRITE_EN(WRITE_EN), .SHIFT_EN(SHIFT_EN),
        .OUT_VALID(OUT_VALID), .FRAME_DONE(FRAME_DONE), .OVERRUN(OVERRUN),
        .ERR_COUNT(ERR_COUNT), .BUSY(BUSY)
    );

    hamming_rx_frame_controller #(.ERRCNT_W(2)) dut_sat (
        .CLK(CLK), .REST(REST), .DEVICE_EN(DEVICE_EN), .BIT_VALID(BIT_VALID),
        .SYNDROME(SYNDROME), .OUT_READY(OUT_READY), .CLR_STATUS(CLR_STATUS),
        .IN_SHIFT_EN(IN_SHIFT_EN2), .WRITE_EN(WRITE_EN2), .SHIFT_EN(SHIFT_EN2),
        .OUT_VALID(OUT_VALID2), .FRAME_DONE(FRAME_DONE2), .OVERRUN(OVERRUN2),
        .ERR_COUNT(ERR_COUNT2), .BUSY(BUSY2)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bits = 0; m_done = 1'b0; m_left = 0; m_ovr = 1'b0; m_err = 0; m_err2 = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_write_en"},  WRITE_EN,   0);
        check_eq({tag, "_shift_en"},  SHIFT_EN,   0);
        check_eq({tag, "_out_valid"}, OUT_VALID,  0);
        check_eq({tag, "_frame_done"}, FRAME_DONE, 0);
        check_eq({tag, "_overrun"},   OVERRUN,    0);
        check_eq({tag, "_busy"},      BUSY,       0);
        check_eq({tag, "_err_count"}, ERR_COUNT,  0);
    endtask

    // One clock cycle: drive inputs, compare against the model, advance it.
    task automatic step(input bit bv, input bit en, input bit rdy,
                        input logic [3:0] syn, input bit clr);
        bit e_busy, e_load, e_shift, done_next;
        @(negedge CLK);
        BIT_VALID = bv; DEVICE_EN = en; OUT_READY = rdy; SYNDROME = syn; CLR_STATUS = clr;
        #1;
        e_busy  = (m_left > 0);
        e_load  = m_done && !e_busy;
        e_shift = e_busy && rdy;
        check_eq("in_shift_en", IN_SHIFT_EN, 32'(bv & en));
        check_eq("write_en",    WRITE_EN,    32'(e_load));
        check_eq("shift_en",    SHIFT_EN,    32'(e_shift));
        check_eq("out_valid",   OUT_VALID,   32'(e_busy));
        check_eq("busy",        BUSY,        32'(e_busy));
        check_eq("frame_done",  FRAME_DONE,  32'(m_done));
        check_eq("overrun",     OVERRUN,     32'(m_ovr));
        check_eq("err_count",   ERR_COUNT,   32'(m_err));
        check_eq("err_count_w2", ERR_COUNT2, 32'(m_err2));

        if (m_done && e_busy) m_ovr = 1'b1;
        if (e_load) begin
            m_left = 11;
            if (syn != 4'd0) begin
                if (m_err  < 255) m_err++;
                if (m_err2 < 3)   m_err2++;
            end
        end else if (e_shift) begin
            m_left--;
        end
        if (clr) begin
            m_ovr = 1'b0; m_err = 0; m_err2 = 0;
        end
        done_next = 1'b0;
        if (!en) begin
            m_bits = 0;
        end else if (bv) begin
            m_bits++;
            if (m_bits == 15) begin
                m_bits = 0;
                done_next = 1'b1;
            end
        end
        m_done = done_next;
    endtask

    // rmode: 0 = ready low, 1 = ready high, 2 = ready toggles each cycle
    task automatic frame(input int rmode, input logic [3:0] syn, input int tail);
        for (int i = 0; i < 15 + tail; i++) begin
            bit r;
            r = (rmode == 1) || (rmode == 2 && (i % 2 == 0));
            step(i < 15, 1'b1, r, syn, 1'b0);
        end
    endtask

    initial begin
        int budget;
        // Reset state
        #1;
        check_all_zero("reset");
        check_eq("reset_in_shift_en", IN_SHIFT_EN, 0);
        @(negedge CLK);
        REST = 1'b1;

        // Full-rate frame, then toggled-ready frame
        frame(1, 4'd0, 16);
        frame(2, 4'd0, 30);

        // Overrun: hold the drain, complete a second frame, then clear
        frame(0, 4'd0, 3);
        frame(0, 4'd0, 3);
        check_eq("overrun_set", OVERRUN, 1);
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        check_eq("overrun_cleared", OVERRUN, 0);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b1, 4'd0, 1'b0);

        // Error counting: 3 errored loads, 2 clean, then saturation of the narrow counter
        step(1'b0, 1'b1, 1'b1, 4'd0, 1'b1);
        frame(1, 4'b0101, 14);
        frame(1, 4'd0,    14);
        frame(1, 4'b0101, 14);
        frame(1, 4'd0,    14);
        frame(1, 4'b0101, 14);
        check_eq("err_count_three", ERR_COUNT, 3);
        for (int f = 0; f < 5; f++) frame(1, 4'b0101, 14);
        check_eq("err_count_eight", ERR_COUNT, 8);
        check_eq("err_count_saturated", ERR_COUNT2, 3);

        // Partial frame discarded by one disabled cycle
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b1, 4'd0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 4'd0, 1'b0);
        frame(1, 4'd0, 16);

        // Reset in the middle of a drain after five shifts
        for (int i = 0; i < 15; i++) step(1'b1, 1'b1, 1'b1, 4'd0, 1'b0);
        budget = 0;
        while (m_left != 6 && budget < 40) begin
            step(1'b0, 1'b1, 1'b1, 4'd0, 1'b0);
            budget++;
        end
        check_eq("drain_reached_mid", 32'(budget < 40), 1);
        @(negedge CLK);
        BIT_VALID = 1'b0; OUT_READY = 1'b1;
        #2;
        REST = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_reset();
        @(negedge CLK);
        REST = 1'b1;
        frame(1, 4'd0, 16);

        // Randomized traffic
        for (int i = 0; i < 2500; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 29) != 0,
                 $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 149) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
